// File: rtl/line_buffer_bank_ring.sv
// Ring of NUM_BANKS line-buffer banks: a producer fills banks NUM_LINES lines at a time,
// and a consumer reads whole columns from the oldest full bank and then releases it.

module line_buffer_bank_ring_line #(
    parameter int DEPTH = 8,
    parameter int IW    = 3,
    parameter int PW    = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [PW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [PW-1:0] rdata_o
);

    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] rdata_q;

    // Storage is intentionally not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)  rdata_q <= '0;
        else if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

module line_buffer_bank_ring #(
    parameter  int NUM_BANKS  = 4,
    parameter  int NUM_LINES  = 3,
    parameter  int LINE_WIDTH = 64,
    parameter  int CHANNELS   = 1,
    parameter  int DATA_WIDTH = 16,
    localparam int AW         = $clog2(LINE_WIDTH),
    localparam int BW         = $clog2(NUM_BANKS),
    localparam int PW         = CHANNELS * DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [PW-1:0]           wr_data_i,
    input  logic                    wr_eol_i,
    output logic                    rd_avail_o,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [NUM_LINES*PW-1:0] rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_release_i,
    output logic [BW-1:0]           wr_bank_o,
    output logic [BW-1:0]           rd_bank_o,
    output logic [NUM_BANKS-1:0]    full_mask_o,
    output logic                    err_eol_o
);

    localparam int LNW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int DEPTH = NUM_BANKS * LINE_WIDTH;
    localparam int IW    = $clog2(DEPTH);

    logic [NUM_BANKS-1:0] full_q, full_d;
    logic [AW-1:0]        col_q, col_d;
    logic [LNW-1:0]       line_q, line_d;
    logic [BW-1:0]        wr_bank_q, wr_bank_d;
    logic [BW-1:0]        rd_bank_q, rd_bank_d;
    logic                 err_q, err_d;
    logic                 rd_valid_q;

    logic accept, col_last, line_last, release_ok, rd_fire;
    logic [IW-1:0] waddr, raddr;

    assign wr_ready_o = ~full_q[wr_bank_q];
    assign rd_avail_o = full_q[rd_bank_q];
    assign accept     = wr_valid_i & wr_ready_o;
    assign col_last   = (col_q == AW'(LINE_WIDTH - 1));
    assign line_last  = (line_q == LNW'(NUM_LINES - 1));
    assign release_ok = rd_release_i & rd_avail_o;
    assign rd_fire    = rd_en_i & rd_avail_o;

    // Completion sets the write bank and release clears the read bank; these are
    // never the same bank, since a bank being filled is not FULL.
    always_comb begin
        full_d    = full_q;
        col_d     = col_q;
        line_d    = line_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = err_q;
        if (accept) begin
            if (wr_eol_i != col_last) err_d = 1'b1;
            if (col_last) begin
                col_d = '0;
                if (line_last) begin
                    line_d            = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d = (wr_bank_q == BW'(NUM_BANKS - 1)) ? '0 : wr_bank_q + 1'b1;
                end else begin
                    line_d = line_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d = (rd_bank_q == BW'(NUM_BANKS - 1)) ? '0 : rd_bank_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            full_q     <= '0;
            col_q      <= '0;
            line_q     <= '0;
            wr_bank_q  <= '0;
            rd_bank_q  <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            col_q      <= col_d;
            line_q     <= line_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            err_q      <= err_d;
            rd_valid_q <= rd_fire;
        end
    end

    assign waddr = IW'(wr_bank_q) * IW'(LINE_WIDTH) + IW'(col_q);
    assign raddr = IW'(rd_bank_q) * IW'(LINE_WIDTH) + IW'(rd_addr_i);

    // One memory per line slot so a column read returns every line at once.
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        line_buffer_bank_ring_line #(
            .DEPTH (DEPTH),
            .IW    (IW),
            .PW    (PW)
        ) u_line (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .we_i    (accept && (line_q == LNW'(l))),
            .waddr_i (waddr),
            .wdata_i (wr_data_i),
            .re_i    (rd_fire),
            .raddr_i (raddr),
            .rdata_o (rd_data_o[l*PW +: PW])
        );
    end

    assign rd_valid_o  = rd_valid_q;
    assign wr_bank_o   = wr_bank_q;
    assign rd_bank_o   = rd_bank_q;
    assign full_mask_o = full_q;
    assign err_eol_o   = err_q;

endmodule

// File: tb/tb_line_buffer_bank_ring.sv
// Randomised and directed bench for line_buffer_bank_ring, checked against a
// counter-based model of the bank ring and a scoreboard for column reads.

module tb_line_buffer_bank_ring;

    localparam int NB = 4;
    localparam int NL = 3;
    localparam int LW = 4;
    localparam int CH = 2;
    localparam int DW = 8;
    localparam int AW = $clog2(LW);
    localparam int BW = $clog2(NB);
    localparam int PW = CH * DW;
    localparam int RW = NL * PW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [PW-1:0] wr_data_i;
    logic          wr_eol_i;
    logic          rd_avail_o;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [RW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic          rd_release_i;
    logic [BW-1:0] wr_bank_o;
    logic [BW-1:0] rd_bank_o;
    logic [NB-1:0] full_mask_o;
    logic          err_eol_o;

    line_buffer_bank_ring #(
        .NUM_BANKS  (NB),
        .NUM_LINES  (NL),
        .LINE_WIDTH (LW),
        .CHANNELS   (CH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .wr_eol_i     (wr_eol_i),
        .rd_avail_o   (rd_avail_o),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .rd_release_i (rd_release_i),
        .wr_bank_o    (wr_bank_o),
        .rd_bank_o    (rd_bank_o),
        .full_mask_o  (full_mask_o),
        .err_eol_o    (err_eol_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the ring is described by how many banks have completed and been released.
    logic [PW-1:0] m_mem [NB][NL][LW];
    int            m_comp, m_rel, m_pix;
    bit            m_err;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] hold_exp;

    function automatic int m_full();
        return m_comp - m_rel;
    endfunction

    function automatic logic [NB-1:0] m_mask();
        logic [NB-1:0] m;
        m = '0;
        for (int k = 0; k < m_full(); k++) m[(m_rel + k) % NB] = 1'b1;
        return m;
    endfunction

    function automatic logic [PW-1:0] pixval(input int i);
        return {8'(i + 128), 8'(i)};
    endfunction

    function automatic bit eol_now();
        return (m_pix % LW) == LW - 1;
    endfunction

    task automatic model_reset();
        m_comp = 0;
        m_rel  = 0;
        m_pix  = 0;
        m_err  = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic v, input logic [PW-1:0] d, input logic e,
                        input logic ren, input logic [AW-1:0] a, input logic rel);
        bit            acc, avail, done;
        logic [RW-1:0] rexp;
        wr_valid_i   = v;
        wr_data_i    = d;
        wr_eol_i     = e;
        rd_en_i      = ren;
        rd_addr_i    = a;
        rd_release_i = rel;
        #1;
        chk("wr_ready", wr_ready_o, m_full() < NB);
        chk("rd_avail", rd_avail_o, m_full() > 0);
        chk("wr_bank", wr_bank_o, m_comp % NB);
        chk("rd_bank", rd_bank_o, m_rel % NB);
        chk("full_mask", full_mask_o, m_mask());
        chk("err_eol", err_eol_o, m_err);
        avail = m_full() > 0;
        acc   = v && (m_full() < NB);
        done  = 0;
        if (ren && avail) begin
            for (int l = 0; l < NL; l++) rexp[l*PW +: PW] = m_mem[m_rel % NB][l][a];
            exp_q.push_back(rexp);
        end
        if (acc) begin
            if (e != eol_now()) m_err = 1;
            m_mem[m_comp % NB][m_pix / LW][m_pix % LW] = d;
            m_pix++;
            if (m_pix == NL * LW) begin
                m_pix = 0;
                done  = 1;
            end
        end
        if (rel && avail) m_rel++;
        if (done) m_comp++;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_wr_ready", wr_ready_o, 1);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_err_eol", err_eol_o, 0);
        chk("rst_full_mask", full_mask_o, 0);
        chk("rst_wr_bank", wr_bank_o, 0);
        chk("rst_rd_bank", rd_bank_o, 0);
    endtask

    // Read monitor: pops on every rd_valid; otherwise rd_data must hold its last value.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            hold_exp = '0;
        end else if (rd_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 1, 0);
            end else begin
                hold_exp = exp_q.pop_front();
                chk("rd_data", rd_data_o, hold_exp);
            end
        end else begin
            chk("rd_data_hold", rd_data_o, hold_exp);
        end
    end

    initial begin
        logic [RW-1:0] exp_t1;
        reset_i      = 1'b0;
        wr_valid_i   = 1'b0;
        wr_data_i    = '0;
        wr_eol_i     = 1'b0;
        rd_en_i      = 1'b0;
        rd_addr_i    = '0;
        rd_release_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs();
        reset_i = 1'b1;

        // Fill bank 0 with pixels 0..11, then read column 2.
        for (int i = 0; i < NL * LW; i++) step(1, pixval(i), (i % LW) == LW - 1, 0, '0, 0);
        chk("t1_full_mask", full_mask_o, 4'b0001);
        chk("t1_wr_bank", wr_bank_o, 1);
        chk("t1_rd_avail", rd_avail_o, 1);
        for (int l = 0; l < NL; l++) exp_t1[l*PW +: PW] = pixval(l * LW + 2);
        step(0, '0, 0, 1, AW'(2), 0);
        chk("t1_rd_valid", rd_valid_o, 1);
        chk("t1_rd_data", rd_data_o, exp_t1);
        idle(1);
        chk("t1_rd_valid_drop", rd_valid_o, 0);

        // Fill the remaining banks with no release: ring full blocks writes.
        for (int i = 0; i < (NB - 1) * NL * LW; i++)
            step(1, pixval(i + 20), (i % LW) == LW - 1, 0, '0, 0);
        chk("t2_wr_ready", wr_ready_o, 0);
        chk("t2_full_mask", full_mask_o, 4'b1111);
        step(1, pixval(99), 0, 0, '0, 0);
        chk("t2_full_mask_hold", full_mask_o, 4'b1111);
        step(0, '0, 0, 1, AW'(1), 1);
        chk("t2_wr_ready_after_rel", wr_ready_o, 1);
        chk("t2_rd_bank", rd_bank_o, 1);
        idle(2);

        // Random traffic: overlaps of fill completion, release, reads and ring-full stalls.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, PW'($urandom), eol_now(),
                 $urandom_range(0, 1), AW'($urandom), $urandom_range(0, 9) == 0);
        idle(3);

        // Reset mid-line (line 1, col 2) then refill bank 0 from col 0.
        reset_i = 1'b0;
        #1;
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int i = 0; i < LW + 2; i++) step(1, pixval(i + 50), (i % LW) == LW - 1, 0, '0, 0);
        reset_i = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int i = 0; i < NL * LW; i++) step(1, pixval(i + 200), (i % LW) == LW - 1, 0, '0, 0);
        chk("t6_full_mask", full_mask_o, 4'b0001);
        chk("t6_wr_bank", wr_bank_o, 1);
        step(0, '0, 0, 1, AW'(0), 0);
        step(0, '0, 0, 1, AW'(3), 0);
        idle(1);

        // Misplaced EOL: error is sticky, framing still follows LINE_WIDTH.
        for (int i = 0; i < LW; i++) step(1, pixval(i + 300), i == 2, 0, '0, 0);
        chk("t4_err_eol", err_eol_o, 1);
        for (int i = LW; i < NL * LW; i++) step(1, pixval(i + 300), (i % LW) == LW - 1, 0, '0, 0);
        chk("t4_err_sticky", err_eol_o, 1);
        chk("t4_full_mask", full_mask_o, 4'b0011);
        chk("t4_wr_bank", wr_bank_o, 2);
        step(0, '0, 0, 1, AW'(1), 1);
        step(0, '0, 0, 1, AW'(2), 0);
        idle(3);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
